// File: rtl/psm_seq.sv
// rtl/psm_seq.sv - three-phase operand sequencer with per-phase bitwise op, chaining and abort
module psm_seq #(
  parameter int WIDTH = 8,
  parameter int LEN1  = 2,
  parameter int LEN2  = 5,
  parameter int LEN3  = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din1,
  input  logic [WIDTH-1:0] Din2,
  input  logic [5:0]       Mode,
  input  logic             Chain,
  input  logic             Start,
  input  logic             Abort,
  output logic             Ready,
  output logic             Op1,
  output logic             Op2,
  output logic             Op3,
  output logic             Done,
  output logic             Aborted,
  output logic [WIDTH-1:0] Dout
);

  localparam int MAXLEN = (LEN1 > LEN2) ? ((LEN1 > LEN3) ? LEN1 : LEN3)
                                        : ((LEN2 > LEN3) ? LEN2 : LEN3);
  // A one-cycle-only build still needs a one-bit counter to stay legal.
  localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [CW-1:0] LAST1 = CW'(LEN1 - 1);
  localparam logic [CW-1:0] LAST2 = CW'(LEN2 - 1);
  localparam logic [CW-1:0] LAST3 = CW'(LEN3 - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH1  = 2'd1;
  localparam logic [1:0] PH2  = 2'd2;
  localparam logic [1:0] PH3  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       mode_q, mode_d;
  logic             chain_q, chain_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [1:0]       op_sel;
  logic [WIDTH-1:0] result;
  logic             phase_last;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   apply_op = a | b;
      2'b01:   apply_op = a ^ b;
      2'b10:   apply_op = a | ~b;
      default: apply_op = a & b;
    endcase
  endfunction

  always_comb begin
    op_sel     = mode_q[1:0];
    phase_last = 1'b0;
    case (state_q)
      PH1: phase_last = (cnt_q == LAST1);
      PH2: begin
        op_sel     = mode_q[3:2];
        phase_last = (cnt_q == LAST2);
      end
      PH3: begin
        op_sel     = mode_q[5:4];
        phase_last = (cnt_q == LAST3);
      end
      default: ;
    endcase
    result = apply_op(op_sel, a_q, b_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    chain_d   = chain_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q == IDLE) begin
      if (Start) begin
        state_d = PH1;
        cnt_d   = '0;
        a_d     = Din1;
        b_d     = Din2;
        mode_d  = Mode;
        chain_d = Chain;
      end
    end else if (Abort) begin
      // Abort wins over a phase ending on the same edge; operands are kept.
      state_d   = IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else if (phase_last) begin
      cnt_d = '0;
      case (state_q)
        PH1: state_d = PH2;
        PH2: state_d = PH3;
        default: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      endcase
      if (chain_q && state_q != PH3) a_d = result;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      chain_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      chain_q   <= chain_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign Ready   = (state_q == IDLE);
  assign Op1     = (state_q == PH1);
  assign Op2     = (state_q == PH2);
  assign Op3     = (state_q == PH3);
  assign Done    = done_q;
  assign Aborted = aborted_q;
  assign Dout    = (state_q == IDLE) ? '0 : result;

endmodule

// File: tb/tb_psm_seq.sv
// tb/tb_psm_seq.sv - self-checking bench for psm_seq: vector table, corner sequences, random vs model
module tb_psm_seq;

  logic       Clock;
  logic       Reset;
  logic [7:0] Din1, Din2;
  logic [5:0] Mode;
  logic       Chain, Start, Abort;
  logic       Ready, Op1, Op2, Op3, Done, Aborted;
  logic [7:0] Dout;
  logic       Ready_s, Op1_s, Op2_s, Op3_s, Done_s, Aborted_s;
  logic [7:0] Dout_s;

  int n_cmp  = 0;
  int n_fail = 0;

  psm_seq dut (
    .Clock(Clock), .Reset(Reset), .Din1(Din1), .Din2(Din2), .Mode(Mode),
    .Chain(Chain), .Start(Start), .Abort(Abort), .Ready(Ready), .Op1(Op1),
    .Op2(Op2), .Op3(Op3), .Done(Done), .Aborted(Aborted), .Dout(Dout)
  );

  psm_seq #(.WIDTH(8), .LEN1(1), .LEN2(1), .LEN3(1)) dut_s (
    .Clock(Clock), .Reset(Reset), .Din1(Din1), .Din2(Din2), .Mode(Mode),
    .Chain(Chain), .Start(Start), .Abort(Abort), .Ready(Ready_s), .Op1(Op1_s),
    .Op2(Op2_s), .Op3(Op3_s), .Done(Done_s), .Aborted(Aborted_s), .Dout(Dout_s)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] din1;
    logic [7:0] din2;
    logic [5:0] mode;
    logic       chain;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
  } vec_t;

  vec_t vecs[5];

  // Sequence-level reference: phase results are worked out once at start.
  bit         m_busy, m_done, m_ab;
  int         m_p;
  logic [7:0] m_r1, m_r2, m_r3;

  function automatic logic [7:0] opf(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a ^ b;
      2'b10:   return ~(~a & b);
      default: return a & b;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ab = 0; m_p = 0;
  endtask

  task automatic model_step();
    logic [7:0] a2, a3;
    m_done = 0;
    m_ab   = 0;
    if (!m_busy) begin
      if (Start) begin
        m_busy = 1;
        m_p    = 0;
        m_r1   = opf(Mode[1:0], Din1, Din2);
        a2     = Chain ? m_r1 : Din1;
        m_r2   = opf(Mode[3:2], a2, Din2);
        a3     = Chain ? m_r2 : Din1;
        m_r3   = opf(Mode[5:4], a3, Din2);
      end
    end else if (Abort) begin
      m_busy = 0;
      m_ab   = 1;
    end else if (m_p == 9) begin
      m_busy = 0;
      m_done = 1;
    end else begin
      m_p++;
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_step();
    @(negedge Clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [7:0] ed;
    ed = !m_busy ? 8'h00 : (m_p < 2) ? m_r1 : (m_p < 7) ? m_r2 : m_r3;
    chk("rnd_ready", Ready, !m_busy);
    chk("rnd_op1", Op1, m_busy && m_p < 2);
    chk("rnd_op2", Op2, m_busy && m_p >= 2 && m_p < 7);
    chk("rnd_op3", Op3, m_busy && m_p >= 7);
    chk("rnd_done", Done, m_done);
    chk("rnd_aborted", Aborted, m_ab);
    chk("rnd_dout", Dout, ed);
  endtask

  task automatic start_seq(input logic [7:0] d1, input logic [7:0] d2, input logic [5:0] md, input logic ch);
    Din1 = d1; Din2 = d2; Mode = md; Chain = ch; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] ed;
    start_seq(v.din1, v.din2, v.mode, v.chain);
    for (int c = 0; c < 10; c++) begin
      ed = (c < 2) ? v.r1 : (c < 7) ? v.r2 : v.r3;
      chk("vec_op1", Op1, c < 2);
      chk("vec_op2", Op2, c >= 2 && c < 7);
      chk("vec_op3", Op3, c >= 7);
      chk("vec_ready", Ready, 1'b0);
      chk("vec_dout", Dout, ed);
      tick();
    end
    chk("vec_done", Done, 1'b1);
    chk("vec_done_ready", Ready, 1'b1);
    chk("vec_done_dout", Dout, 8'h00);
    chk("vec_done_noabort", Aborted, 1'b0);
    tick();
    chk("vec_done_pulse", Done, 1'b0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 6'b10_01_00, 1'b0, 8'hBD, 8'h99, 8'hE7};
    vecs[1] = '{8'hA5, 8'h3C, 6'b10_01_00, 1'b1, 8'hBD, 8'h81, 8'hC3};
    vecs[2] = '{8'hA5, 8'h3C, 6'b11_11_11, 1'b0, 8'h24, 8'h24, 8'h24};
    vecs[3] = '{8'h0F, 8'hF0, 6'b11_10_01, 1'b1, 8'hFF, 8'hFF, 8'hF0};
    vecs[4] = '{8'h0F, 8'hF0, 6'b11_10_01, 1'b0, 8'hFF, 8'h0F, 8'h00};

    Din1 = '0; Din2 = '0; Mode = '0; Chain = 0; Start = 0; Abort = 0;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_ready", Ready, 1'b1);
    chk("rst_ops", {Op1, Op2, Op3}, 3'b000);
    chk("rst_pulses", {Done, Aborted}, 2'b00);
    chk("rst_dout", Dout, 8'h00);
    tick();
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort on the third PH2 cycle.
    start_seq(8'hA5, 8'h3C, 6'b10_01_00, 1'b0);
    repeat (4) tick();
    chk("abt_in_ph2", Op2, 1'b1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abt_ready", Ready, 1'b1);
    chk("abt_pulse", Aborted, 1'b1);
    chk("abt_nodone", Done, 1'b0);
    chk("abt_dout", Dout, 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abt_after_done", Done, 1'b0);
      chk("abt_after_pulse", Aborted, 1'b0);
    end

    // Abort on the final PH3 cycle beats completion.
    start_seq(8'hA5, 8'h3C, 6'b10_01_00, 1'b0);
    repeat (9) tick();
    chk("abtlast_op3", Op3, 1'b1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abtlast_aborted", Aborted, 1'b1);
    chk("abtlast_nodone", Done, 1'b0);
    tick();

    // Start held high: timing unchanged, restart in the Done cycle with fresh operands.
    Din1 = 8'hA5; Din2 = 8'h3C; Mode = 6'b10_01_00; Chain = 0; Start = 1'b1;
    tick();
    Din1 = 8'h0F; Din2 = 8'hF0;
    repeat (9) tick();
    chk("hold_op3_last", Op3, 1'b1);
    chk("hold_dout3", Dout, 8'hE7);
    tick();
    chk("hold_done", Done, 1'b1);
    chk("hold_ready", Ready, 1'b1);
    tick();
    Start = 1'b0;
    chk("hold_restart_op1", Op1, 1'b1);
    chk("hold_restart_dout", Dout, 8'hFF);
    repeat (10) tick();
    chk("hold_done2", Done, 1'b1);

    // Start and Abort together in IDLE: Start wins.
    Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    chk("sa_op1", Op1, 1'b1);
    chk("sa_noabort", Aborted, 1'b0);
    repeat (10) tick();
    chk("sa_done", Done, 1'b1);
    tick();

    // Asynchronous reset mid-PH3.
    start_seq(8'hA5, 8'h3C, 6'b10_01_00, 1'b1);
    repeat (8) tick();
    chk("mrst_op3", Op3, 1'b1);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("mrst_ready", Ready, 1'b1);
    chk("mrst_op3_clr", Op3, 1'b0);
    chk("mrst_dout", Dout, 8'h00);
    chk("mrst_pulses", {Done, Aborted}, 2'b00);
    tick();
    Reset = 1'b0;
    tick();
    chk("mrst_after_pulses", {Done, Aborted}, 2'b00);
    chk("mrst_after_ready", Ready, 1'b1);

    // Single-cycle phase build.
    start_seq(8'hA5, 8'h3C, 6'b10_01_00, 1'b0);
    chk("s1_op1", {Ready_s, Op1_s, Op2_s, Op3_s}, 4'b0100);
    chk("s1_dout1", Dout_s, 8'hBD);
    tick();
    chk("s1_op2", {Ready_s, Op1_s, Op2_s, Op3_s}, 4'b0010);
    chk("s1_dout2", Dout_s, 8'h99);
    tick();
    chk("s1_op3", {Ready_s, Op1_s, Op2_s, Op3_s}, 4'b0001);
    chk("s1_dout3", Dout_s, 8'hE7);
    tick();
    chk("s1_done", {Ready_s, Done_s, Aborted_s}, 3'b110);
    tick();
    chk("s1_done_pulse", Done_s, 1'b0);

    // Randomized run against the reference model.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      chk_model();
      Start = ($urandom_range(0, 2) == 0);
      Abort = ($urandom_range(0, 11) == 0);
      Din1  = 8'($urandom);
      Din2  = 8'($urandom);
      Mode  = 6'($urandom);
      Chain = 1'($urandom);
      tick();
    end
    chk_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
